sram_arbiter: RTL

- Parametrised single-port SRAM arbiter and successor to the fixed 800x600 SRAM front end.
- Merges three sources into one SRAM op per cycle: pipeline foreground reads, ADC pixel writes and SPI image writes.
- Adds a buffered SPI path with a valid/ready handshake, frame-aligned freeze, configurable resolution, widths and SRAM read latency, plus a dropped-pixel status counter.
- Sits between the pipeline/ADC FIFO/SPI receiver and sram_interface.

---
 rtl/sram_arbiter.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/sram_arbiter.sv
// Single-port SRAM arbiter: merges pipeline reads, ADC pixel writes and buffered
// SPI image writes into one SRAM op per cycle, with frame-aligned freeze.
module sram_arbiter #(
  parameter int X_RES          = 800,
  parameter int Y_RES          = 600,
  parameter int COORD_W        = 11,
  parameter int AXIS_BITS      = 10,
  parameter int PIXEL_W        = 16,
  parameter int SRAM_DATA_W    = 17,
  parameter int SRAM_LATENCY   = 5,
  parameter int SPI_FIFO_DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       freeze_req,
  output logic                       frozen,
  input  logic                       spi_valid,
  output logic                       spi_ready,
  input  logic [PIXEL_W-1:0]         spi_pixel_in,
  input  logic [COORD_W-1:0]         spi_pixel_x,
  input  logic [COORD_W-1:0]         spi_pixel_y,
  input  logic [2*COORD_W+PIXEL_W-1:0] adc_pixel_data,
  input  logic                       adc_pixel_ready,
  output logic                       adc_pixel_read,
  input  logic                       request_active,
  input  logic [COORD_W-1:0]         request_x,
  input  logic [COORD_W-1:0]         request_y,
  output logic [PIXEL_W-1:0]         request_data,
  output logic                       request_ready,
  output logic                       sram_we,
  output logic [2*AXIS_BITS-1:0]     sram_addr,
  output logic [SRAM_DATA_W-1:0]     sram_data_in,
  input  logic [SRAM_DATA_W-1:0]     sram_data_out,
  output logic [15:0]                adc_drop_count
);
  localparam int ENT_W = 2*COORD_W+PIXEL_W;
  localparam int PTR_W = $clog2(SPI_FIFO_DEPTH);
  localparam int LAT   = SRAM_LATENCY;
  localparam logic [COORD_W-1:0] X_LIM = COORD_W'(X_RES);
  localparam logic [COORD_W-1:0] Y_LIM = COORD_W'(Y_RES);
  localparam logic [PTR_W:0]     FULL  = (PTR_W+1)'(SPI_FIFO_DEPTH);
  localparam logic [0:0] LIVE   = 1'b0;
  localparam logic [0:0] FROZEN = 1'b1;

  function automatic logic in_range(input logic [COORD_W-1:0] x, input logic [COORD_W-1:0] y);
    return (x < X_LIM) && (y < Y_LIM);
  endfunction

  function automatic logic [2*AXIS_BITS-1:0] addr_of(input logic [COORD_W-1:0] x, input logic [COORD_W-1:0] y);
    return {x[AXIS_BITS-1:0], y[AXIS_BITS-1:0]};
  endfunction

  function automatic logic [SRAM_DATA_W-1:0] widen(input logic [PIXEL_W-1:0] p);
    logic [SRAM_DATA_W-1:0] w;
    w = '0;
    w[PIXEL_W-1:0] = p;
    return w;
  endfunction

  logic [ENT_W-1:0]       fifo_q [SPI_FIFO_DEPTH];
  logic [PTR_W:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic                   spi_ready_q, spi_ready_d;
  logic [0:0]             state_q, state_d;
  logic [15:0]            drop_q, drop_d;
  logic                   adc_read_q, adc_read_d;
  logic                   we_q, we_d;
  logic [2*AXIS_BITS-1:0] addr_q, addr_d;
  logic [SRAM_DATA_W-1:0] wdata_q, wdata_d;
  logic [LAT:0]           vld_pipe_q, vld_pipe_d, inr_pipe_q, inr_pipe_d;
  logic                   rdy_q, rdy_d;
  logic [PIXEL_W-1:0]     rdata_q, rdata_d;

  logic [COORD_W-1:0] adc_x, adc_y, head_x, head_y;
  logic [PIXEL_W-1:0] adc_pix, head_pix;
  logic [ENT_W-1:0]   head;
  logic rd_inr, adc_gnt, spi_pop, spi_push;
  logic unused_sram_bits;

  assign unused_sram_bits = ^sram_data_out;
  assign {adc_x, adc_y, adc_pix} = adc_pixel_data;
  assign head = fifo_q[rd_ptr_q[PTR_W-1:0]];
  assign {head_x, head_y, head_pix} = head;

  // adc_pixel_read is registered, so the FIFO head only advances a cycle after
  // the pop; skipping that cycle keeps the same pixel from being granted twice.
  assign rd_inr   = request_active && in_range(request_x, request_y);
  assign adc_gnt  = adc_pixel_ready && !rd_inr && !adc_read_q;
  assign spi_pop  = (wr_ptr_q != rd_ptr_q) && !rd_inr && !adc_gnt;
  assign spi_push = spi_valid && spi_ready_q;

  always_comb begin
    state_d = state_q;
    if (adc_gnt && adc_x == '0 && adc_y == '0) begin
      if (state_q == LIVE && freeze_req)        state_d = FROZEN;
      else if (state_q == FROZEN && !freeze_req) state_d = LIVE;
    end

    // The (0,0) pixel follows the state it switches into: dropped on entry, written on exit.
    drop_d = drop_q;
    if (adc_gnt && state_d == FROZEN && drop_q != 16'hFFFF) drop_d = drop_q + 16'd1;

    adc_read_d = adc_gnt;
    we_d    = 1'b0;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    if (rd_inr) begin
      addr_d = addr_of(request_x, request_y);
    end else if (adc_gnt) begin
      if (state_d == LIVE && in_range(adc_x, adc_y)) begin
        we_d    = 1'b1;
        addr_d  = addr_of(adc_x, adc_y);
        wdata_d = widen(adc_pix);
      end
    end else if (spi_pop && in_range(head_x, head_y)) begin
      we_d    = 1'b1;
      addr_d  = addr_of(head_x, head_y);
      wdata_d = widen(head_pix);
    end

    wr_ptr_d    = wr_ptr_q + (PTR_W+1)'(spi_push);
    rd_ptr_d    = rd_ptr_q + (PTR_W+1)'(spi_pop);
    spi_ready_d = (wr_ptr_d - rd_ptr_d) != FULL;

    vld_pipe_d = {vld_pipe_q[LAT-1:0], request_active};
    inr_pipe_d = {inr_pipe_q[LAT-1:0], rd_inr};
    rdy_d      = vld_pipe_q[LAT];
    rdata_d    = inr_pipe_q[LAT] ? sram_data_out[PIXEL_W-1:0] : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      spi_ready_q <= 1'b0;
      state_q     <= LIVE;
      drop_q      <= '0;
      adc_read_q  <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      vld_pipe_q  <= '0;
      inr_pipe_q  <= '0;
      rdy_q       <= 1'b0;
      rdata_q     <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      spi_ready_q <= spi_ready_d;
      state_q     <= state_d;
      drop_q      <= drop_d;
      adc_read_q  <= adc_read_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      vld_pipe_q  <= vld_pipe_d;
      inr_pipe_q  <= inr_pipe_d;
      rdy_q       <= rdy_d;
      rdata_q     <= rdata_d;
    end
  end

  always_ff @(posedge clk) begin
    if (spi_push) fifo_q[wr_ptr_q[PTR_W-1:0]] <= {spi_pixel_x, spi_pixel_y, spi_pixel_in};
  end

  assign frozen         = (state_q == FROZEN);
  assign spi_ready      = spi_ready_q;
  assign adc_pixel_read = adc_read_q;
  assign request_data   = rdata_q;
  assign request_ready  = rdy_q;
  assign sram_we        = we_q;
  assign sram_addr      = addr_q;
  assign sram_data_in   = wdata_q;
  assign adc_drop_count = drop_q;
endmodule
